// File: rtl/stage3_fc_ctrl_pkg.sv
// Shared stage-3 FC1 definitions: layer geometry, datapath widths, sequencer states.
package stage3_fc_ctrl_pkg;

  localparam int IN_LEN    = 48;
  localparam int CO        = 3;
  localparam int IN_BW     = 8;
  localparam int W_BW      = 8;
  localparam int ACC_BW    = 24;
  localparam int AW        = 6;
  localparam int PROD_BW   = IN_BW + W_BW;
  localparam int DRAIN_CYC = 2;

  // Index of the final feature in a frame; also the last weight row.
  localparam logic [AW-1:0] LAST_IDX = AW'(IN_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EMIT  = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  // Sign-extend a full-width product into the accumulator width.
  function automatic logic [ACC_BW-1:0] sext_prod(input logic [PROD_BW-1:0] p);
    return {{(ACC_BW - PROD_BW){p[PROD_BW-1]}}, p};
  endfunction

endpackage

// File: rtl/stage3_fc_ctrl_if.sv
// Bus bundle between the FC1 sequencer, the pooling buffer, the weight ROM and the core.
//
// Handshake rules:
//  - Feature stream: a feature transfers on a rising edge where i_feat_valid and
//    o_feat_ready are both 1. The producer holds data/last stable while valid is
//    high and not yet accepted; ready does not depend on valid.
//  - Weight ROM: o_w_addr is the ROM's address register. i_w_data must equal the
//    row at o_w_addr, so a row is usable the cycle after its feature's handshake.
//  - Core: o_acc_valid is a one-cycle pulse with o_acc stable from that cycle until
//    the next accepted start; i_core_valid is a one-cycle result strobe.
interface stage3_fc_ctrl_if;
  import stage3_fc_ctrl_pkg::*;

  logic                   i_feat_valid;
  logic                   o_feat_ready;
  logic [IN_BW-1:0]       i_feat_data;
  logic                   i_feat_last;
  logic [AW-1:0]          o_w_addr;
  logic [CO*W_BW-1:0]     i_w_data;
  logic                   o_acc_valid;
  logic [CO*ACC_BW-1:0]   o_acc;
  logic                   i_core_valid;

  // Sequencer side.
  modport slave (
    input  i_feat_valid, i_feat_data, i_feat_last, i_w_data, i_core_valid,
    output o_feat_ready, o_w_addr, o_acc_valid, o_acc
  );

  // Environment side: pooling buffer, weight ROM and core together.
  modport master (
    output i_feat_valid, i_feat_data, i_feat_last, i_w_data, i_core_valid,
    input  o_feat_ready, o_w_addr, o_acc_valid, o_acc
  );

endinterface

// File: rtl/stage3_fc_mac.sv
// One FC1 output channel: registered signed product followed by a wrapping accumulator.
module stage3_fc_mac
  import stage3_fc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_prod_en,
  input  logic              i_acc_en,
  input  logic [IN_BW-1:0]  i_feat,
  input  logic [W_BW-1:0]   i_w,
  output logic [ACC_BW-1:0] o_acc
);

  logic signed [PROD_BW-1:0] w_feat_x;
  logic signed [PROD_BW-1:0] w_w_x;
  logic        [PROD_BW-1:0] r_prod;
  logic        [ACC_BW-1:0]  r_acc;

  // Both operands are widened to the product width so the multiply is exact.
  assign w_feat_x = {{W_BW{i_feat[IN_BW-1]}}, i_feat};
  assign w_w_x    = {{IN_BW{i_w[W_BW-1]}}, i_w};

  // Product stage: captures feature * weight when a registered feature is present.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_prod <= '0;
    end else if (i_prod_en) begin
      r_prod <= w_feat_x * w_w_x;
    end
  end

  // Accumulate stage: two's-complement add that wraps on overflow.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_acc <= '0;
    end else if (i_acc_en) begin
      r_acc <= r_acc + sext_prod(r_prod);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/stage3_fc_ctrl.sv
// Stage-3 FC1 sequencer: accepts one frame of pooled features, runs CO parallel
// MACs against the matching weight rows, hands the sums to the core and waits
// for its result before re-arming.
module stage3_fc_ctrl
  import stage3_fc_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  stage3_fc_ctrl_if.slave  bus,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output state_t           o_dbg_state
);

  state_t               r_state;
  state_t               w_next_state;
  logic [AW-1:0]        r_cnt;
  logic [AW-1:0]        r_w_addr;
  logic [IN_BW-1:0]     r_feat;
  logic [1:0]           r_drain_cnt;
  logic                 r_v1;
  logic                 r_v2;
  logic                 r_err;

  logic                 w_hs;
  logic                 w_start_ok;
  logic                 w_last_cnt;
  logic                 w_feat_ready;
  logic                 w_acc_valid;
  logic                 w_done;
  logic                 w_busy;
  logic [CO*ACC_BW-1:0] w_acc;

  assign w_start_ok = (r_state == ST_IDLE) && i_start;
  assign w_hs       = (r_state == ST_ACCUM) && bus.i_feat_valid;
  assign w_last_cnt = (r_cnt == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_next_state = r_state;
    w_feat_ready = 1'b0;
    w_acc_valid  = 1'b0;
    w_done       = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (i_start) w_next_state = ST_ACCUM;
      end
      ST_ACCUM: begin
        w_feat_ready = 1'b1;
        if (w_hs && w_last_cnt) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_drain_cnt == 2'(DRAIN_CYC - 1)) w_next_state = ST_EMIT;
      end
      ST_EMIT: begin
        w_acc_valid  = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.i_core_valid) begin
          w_done       = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_busy       = 1'b0;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Drain timer: counts the cycles the last feature needs to reach the accumulators.
  always_ff @(posedge clk) begin
    if (reset || (r_state != ST_DRAIN)) begin
      r_drain_cnt <= '0;
    end else begin
      r_drain_cnt <= r_drain_cnt + 2'd1;
    end
  end

  // Feature counter, ROM address and feature register, advanced per handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_w_addr <= '0;
      r_feat   <= '0;
    end else if (w_start_ok) begin
      r_cnt <= '0;
    end else if (w_hs) begin
      r_w_addr <= r_cnt;
      r_feat   <= bus.i_feat_data;
      r_cnt    <= r_cnt + AW'(1);
    end
  end

  // Pipeline valid bits: feature registered (v1), product registered (v2).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= w_hs;
      r_v2 <= r_v1;
    end
  end

  // Sticky framing error: last flag must coincide exactly with the final count.
  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      r_err <= 1'b0;
    end else if (w_hs && (bus.i_feat_last != w_last_cnt)) begin
      r_err <= 1'b1;
    end
  end

  for (genvar c = 0; c < CO; c++) begin : g_mac
    stage3_fc_mac u_mac (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (w_start_ok),
      .i_prod_en (r_v1),
      .i_acc_en  (r_v2),
      .i_feat    (r_feat),
      .i_w       (bus.i_w_data[c*W_BW +: W_BW]),
      .o_acc     (w_acc[c*ACC_BW +: ACC_BW])
    );
  end

  assign bus.o_feat_ready = w_feat_ready;
  assign bus.o_w_addr     = r_w_addr;
  assign bus.o_acc_valid  = w_acc_valid;
  assign bus.o_acc        = w_acc;
  assign o_busy           = w_busy;
  assign o_done           = w_done;
  assign o_err            = r_err;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_stage3_fc_ctrl.sv
// Self-checking bench for the stage-3 FC1 sequencer.
module tb_stage3_fc_ctrl;
  import stage3_fc_ctrl_pkg::*;

  localparam int AB = CO * ACC_BW;

  logic   clk;
  logic   reset;
  logic   i_start;
  logic   o_busy;
  logic   o_done;
  logic   o_err;
  state_t o_dbg_state;

  stage3_fc_ctrl_if bus ();

  stage3_fc_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .bus         (bus),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- weight ROM and frame data ----------------
  logic [IN_BW-1:0]   feat_mem [IN_LEN];
  logic [CO*W_BW-1:0] rom_mem  [IN_LEN];

  assign bus.i_w_data = rom_mem[bus.o_w_addr];

  // ---------------- scoreboard ----------------
  logic [AB-1:0] exp_q[$];
  logic          exp_err_q[$];
  logic          exp_ready;
  logic          exp_done;
  int            n_vec;
  int            n_err;

  task automatic chk(input string name, input logic [AB-1:0] act, input logic [AB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each channel is the plain dot product of the frame with its weight column.
  function automatic logic [AB-1:0] golden();
    logic [AB-1:0]     r;
    logic signed [31:0] sum;
    int                fv;
    int                wv;
    r = '0;
    for (int c = 0; c < CO; c++) begin
      sum = 0;
      for (int i = 0; i < IN_LEN; i++) begin
        fv  = int'($signed(feat_mem[i]));
        wv  = int'($signed(rom_mem[i][c*W_BW +: W_BW]));
        sum = sum + fv * wv;
      end
      r[c*ACC_BW +: ACC_BW] = sum[ACC_BW-1:0];
    end
    return r;
  endfunction

  // Monitor: per-cycle ready/done expectations and result checking on o_acc_valid.
  always @(negedge clk) begin
    logic [AB-1:0] e;
    logic          ee;
    if (!reset) begin
      chk("feat_ready", {{(AB-1){1'b0}}, bus.o_feat_ready}, {{(AB-1){1'b0}}, exp_ready});
      chk("done", {{(AB-1){1'b0}}, o_done}, {{(AB-1){1'b0}}, exp_done});
      if (bus.o_acc_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("acc_valid_unexpected", {{(AB-1){1'b0}}, bus.o_acc_valid}, '0);
        end else begin
          e  = exp_q.pop_front();
          ee = exp_err_q.pop_front();
          chk("acc", bus.o_acc, e);
          chk("err_at_emit", {{(AB-1){1'b0}}, o_err}, {{(AB-1){1'b0}}, ee});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic fill_const(input logic [IN_BW-1:0] f, input logic [W_BW-1:0] w0,
                            input logic [W_BW-1:0] w1, input logic [W_BW-1:0] w2);
    for (int i = 0; i < IN_LEN; i++) begin
      feat_mem[i] = f;
      rom_mem[i]  = {w2, w1, w0};
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < IN_LEN; i++) begin
      feat_mem[i] = IN_BW'($urandom_range(0, 255));
      rom_mem[i]  = (CO*W_BW)'($urandom);
    end
  endtask

  // One frame. last_mode: 0 correct, 1 extra last at feature 10, 2 last never set.
  // abort_at >= 0 resets the DUT when that many features have been accepted.
  task automatic run_frame(input int gap_pct, input int last_mode, input int abort_at,
                           input bit noise, input bit emit_cv);
    int i;
    int cyc;
    int d;
    bit hs;
    bit aborted;
    i       = 0;
    cyc     = 0;
    aborted = 1'b0;
    if (abort_at < 0) begin
      exp_q.push_back(golden());
      exp_err_q.push_back(last_mode != 0);
    end
    // start pulse, then one idle cycle to confirm the error flag was cleared
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start   = 1'b0;
    exp_ready = 1'b1;
    @(negedge clk);
    chk("err_cleared", {{(AB-1){1'b0}}, o_err}, '0);
    chk("busy_accum", {{(AB-1){1'b0}}, o_busy}, {{(AB-1){1'b0}}, 1'b1});
    @(posedge clk); #1;
    while (i < IN_LEN && cyc < 2000) begin
      if (abort_at >= 0 && i == abort_at) begin
        bus.i_feat_valid = 1'b0;
        i_start          = 1'b0;
        bus.i_core_valid = 1'b0;
        reset            = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        exp_ready = 1'b0;
        aborted   = 1'b1;
        break;
      end
      bus.i_feat_valid = ($urandom_range(0, 99) >= gap_pct);
      bus.i_feat_data  = feat_mem[i];
      case (last_mode)
        1:       bus.i_feat_last = (i == 10) || (i == IN_LEN - 1);
        2:       bus.i_feat_last = 1'b0;
        default: bus.i_feat_last = (i == IN_LEN - 1);
      endcase
      i_start          = noise && (cyc == 5);
      bus.i_core_valid = noise && (cyc == 5);
      @(negedge clk);
      hs = bus.i_feat_valid && bus.o_feat_ready;
      @(posedge clk); #1;
      if (hs) i++;
      cyc++;
    end
    bus.i_feat_valid = 1'b0;
    bus.i_feat_last  = 1'b0;
    i_start          = 1'b0;
    bus.i_core_valid = 1'b0;
    if (aborted) begin
      repeat (8) begin
        @(negedge clk);
        chk("busy_after_abort", {{(AB-1){1'b0}}, o_busy}, '0);
      end
      @(posedge clk); #1;
      return;
    end
    exp_ready = 1'b0;
    if (i < IN_LEN) chk("hs_timeout", AB'(i), AB'(IN_LEN));
    // last handshake was at the end of cycle k; the pulse belongs in cycle k+3
    @(negedge clk);
    chk("acc_valid_k1", {{(AB-1){1'b0}}, bus.o_acc_valid}, '0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("acc_valid_k2", {{(AB-1){1'b0}}, bus.o_acc_valid}, '0);
    @(posedge clk); #1;
    if (emit_cv) bus.i_core_valid = 1'b1;
    @(negedge clk);
    chk("acc_valid_k3", {{(AB-1){1'b0}}, bus.o_acc_valid}, {{(AB-1){1'b0}}, 1'b1});
    @(posedge clk); #1;
    bus.i_core_valid = 1'b0;
    d = $urandom_range(0, 3);
    for (int j = 0; j < d; j++) begin
      i_start = noise;
      @(negedge clk);
      chk("busy_wait", {{(AB-1){1'b0}}, o_busy}, {{(AB-1){1'b0}}, 1'b1});
      @(posedge clk); #1;
      i_start = 1'b0;
    end
    bus.i_core_valid = 1'b1;
    exp_done         = 1'b1;
    @(posedge clk); #1;
    bus.i_core_valid = 1'b0;
    exp_done         = 1'b0;
    @(negedge clk);
    chk("busy_idle", {{(AB-1){1'b0}}, o_busy}, '0);
    chk("state_idle", AB'(o_dbg_state), AB'(ST_IDLE));
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_vec            = 0;
    n_err            = 0;
    exp_ready        = 1'b0;
    exp_done         = 1'b0;
    reset            = 1'b1;
    i_start          = 1'b0;
    bus.i_feat_valid = 1'b0;
    bus.i_feat_data  = '0;
    bus.i_feat_last  = 1'b0;
    bus.i_core_valid = 1'b0;
    fill_const(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_busy", {{(AB-1){1'b0}}, o_busy}, '0);
    chk("rst_err", {{(AB-1){1'b0}}, o_err}, '0);
    chk("rst_acc_valid", {{(AB-1){1'b0}}, bus.o_acc_valid}, '0);
    chk("rst_acc", bus.o_acc, '0);
    chk("rst_w_addr", AB'(bus.o_w_addr), '0);
    @(posedge clk); #1;

    // all ones: each channel sums to IN_LEN
    fill_const(8'h01, 8'h01, 8'h01, 8'h01);
    run_frame(0, 0, -1, 1'b0, 1'b0);

    // extreme operands: largest magnitudes without wrap
    fill_const(8'h80, 8'h80, 8'h7f, 8'h01);
    run_frame(0, 0, -1, 1'b0, 1'b0);

    // random data with ~50% valid gaps
    for (int k = 0; k < 4; k++) begin
      fill_rand();
      run_frame(50, 0, -1, 1'b0, k[0]);
    end

    // early last, then a clean frame that clears the error
    fill_rand();
    run_frame(30, 1, -1, 1'b0, 1'b0);
    fill_rand();
    run_frame(0, 0, -1, 1'b0, 1'b0);

    // last never asserted
    fill_rand();
    run_frame(20, 2, -1, 1'b0, 1'b0);

    // mid-frame reset, then the same frame run cleanly
    fill_rand();
    run_frame(25, 0, 20, 1'b0, 1'b0);
    run_frame(25, 0, -1, 1'b0, 1'b0);

    // stray start / core_valid during ACCUM, start during WAIT, core_valid in EMIT
    for (int k = 0; k < 3; k++) begin
      fill_rand();
      run_frame(40, 0, -1, 1'b1, 1'b1);
    end

    repeat (4) @(posedge clk);
    chk("exp_q_left", AB'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
